spu_decode_stage: RTL and testbench
===================================

# spu_decode_stage

Parametrised, buffered decode stage for the SPU pipeline, sitting between instruction fetch and the register file / issue logic. It accepts one 32-bit instruction per cycle with its PC+8 value, classifies the instruction format (RRR, RR/RI7, RI10, RI16, RI18), and extracts register addresses, read enables, the destination register and a 32-bit extended immediate. Decoded results are held in a DEPTH-entry FIFO with valid/ready handshakes on both sides and a synchronous flush for branch redirect.

## Interface
- DEPTH, 2: decoded-entry FIFO depth; power of two, ≥2.
- PC_W, 32: width of pc_plus8 path.
- REG_AW, 7: register address width (128 registers).
- CNT_W, 32: width of decoded-instruction counter.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- flush  in  1  synchronous; empties FIFO, drops same-cycle input.
- in_valid  in  1  instruction/pc presented.
- in_ready  out  1  stage can accept this cycle.
- instruction  in  32  raw instruction, bit 31 = MSB of opcode.
- pc_plus8_in  in  PC_W  PC+8 of the instruction.
- out_valid  out  1  FIFO head holds a decoded entry.
- out_ready  in  1  consumer takes head this cycle.
- fmt  out  3  0=RR, 1=RRR, 2=RI10, 3=RI16, 4=RI18.
- opcode  out  11  instruction[31:21], unmodified.
- rt, ra, rb, rc  out  REG_AW each  destination and source addresses.
- ra_en, rb_en, rc_en  out  1 each  source read enables.
- imm  out  32  extended immediate (0 for RR/RRR).
- pc_plus8_out  out  PC_W  passed through with entry.
- decoded_count  out  CNT_W  number of entries pushed since reset.

## Operation
- Classification, first match wins, on instruction[31:x]:
  - RRR: [31:28] ∈ {8,B,C,D,E,F}.
  - RI18: [31:25] ∈ {0x21, 0x08, 0x09}.
  - RI16: [31:28] ∈ {2,4}.
  - RI10: [31:28] ∈ {0,1,3,5,7}.
  - RR (incl. RI7): everything else.
- Fields: RRR: rt=[27:21], rb=[20:14], ra=[13:7], rc=[6:0], ra/rb/rc_en=1. RR: rt=[6:0], ra=[13:7], rb=[20:14], ra_en=rb_en=1. RI10: rt=[6:0], ra=[13:7], ra_en=1, imm=sign-extend [23:14]. RI16: rt=[6:0], imm=sign-extend [22:7]. RI18: rt=[6:0], imm=zero-extend [24:7]. Unused address outputs and enables = 0.
- Decode is combinational on the input. The decoded record is written into the FIFO on push = in_valid & in_ready & !flush.
- Pop = out_valid & out_ready & !flush. All output fields come from the FIFO head storage.
- in_ready = (count < DEPTH). It is derived only from registered count, with no combinational path from out_ready.
- When not full, push and pop in the same cycle: count unchanged, pointers wrap mod DEPTH.
- flush: count←0, read/write pointers←0, and the push is suppressed. decoded_count is not cleared by flush.
- decoded_count increments on each push and saturates at all-ones.

## Timing
- Latency: an instruction pushed at edge N has out_valid=1 and its fields on the outputs after edge N (cycle N+1) if the FIFO was empty.
- Sustained throughput is 1 instruction/cycle when out_ready is held high.
- When full: in_ready=0. A pop at edge N sets in_ready=1 in cycle N+1.
- Priority: reset > flush > push/pop.
- Reset values: out_valid=0, in_ready=1, all fields 0, decoded_count=0, pointers and count 0.
- Reset or flush asserted mid-stream discards all buffered entries within one edge. The next push is accepted the cycle after.
- Outputs are stable while out_valid=1 and out_ready=0.

## Test plan
- RRR: push 0xC0A0C101 with pc 0x108 → next cycle out_valid=1, fmt=1, rt=5, rb=3, ra=2, rc=1, all enables 1, imm=0, pc_plus8_out=0x108.
- RI10/RI16/RI18 immediates:
  - 0x1CFFC209 → fmt=2, rt=9, ra=4, ra_en=1, imm=0xFFFFFFFF.
  - 0x40C00003 → fmt=3, rt=3, imm=0xFFFF8000.
  - 0x43FFFF87 → fmt=4, rt=7, imm=0x0003FFFF.
- Backpressure: DEPTH=2, out_ready=0, push 3 back-to-back → in_ready=0 after the 2nd push and the 3rd is held. Raise out_ready → entries emerge in order with no loss or duplication, and in_ready returns 1 one cycle after the first pop.
- Streaming: out_ready=1, 16 consecutive pushes → 16 outputs in order on 16 consecutive cycles. decoded_count=16, and pointer wrap is exercised.
- Flush: FIFO holding 2 entries, flush with in_valid=1 → next cycle out_valid=0, in_ready=1, count 0, flushed input never appears, decoded_count unchanged.
- Reset mid-operation: reset while full with out_ready=1 → next cycle all outputs at reset values, decoded_count=0. A push after deassertion decodes normally.

Source files
------------

// File: rtl/spu_decode_stage.sv
// SPU decode stage: classifies each 32-bit instruction, extracts register
// fields and the extended immediate, and buffers decoded records in a small FIFO.
module spu_decode_stage #(
   parameter int DEPTH  = 2,
   parameter int PC_W   = 32,
   parameter int REG_AW = 7,
   parameter int CNT_W  = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [31:0]       instruction,
   input  logic [PC_W-1:0]   pc_plus8_in,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [2:0]        fmt,
   output logic [10:0]       opcode,
   output logic [REG_AW-1:0] rt,
   output logic [REG_AW-1:0] ra,
   output logic [REG_AW-1:0] rb,
   output logic [REG_AW-1:0] rc,
   output logic              ra_en,
   output logic              rb_en,
   output logic              rc_en,
   output logic [31:0]       imm,
   output logic [PC_W-1:0]   pc_plus8_out,
   output logic [CNT_W-1:0]  decoded_count
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW    = $clog2(DEPTH + 1);
   localparam int REC_W = 3 + 11 + 4 * REG_AW + 3 + 32 + PC_W;

   localparam logic [2:0] FMT_RR   = 3'd0;
   localparam logic [2:0] FMT_RRR  = 3'd1;
   localparam logic [2:0] FMT_RI10 = 3'd2;
   localparam logic [2:0] FMT_RI16 = 3'd3;
   localparam logic [2:0] FMT_RI18 = 3'd4;

   logic [2:0]        dec_fmt;
   logic [REG_AW-1:0] dec_rt, dec_ra, dec_rb, dec_rc;
   logic [2:0]        dec_en;
   logic [31:0]       dec_imm;
   logic [REC_W-1:0]  dec_rec;

   logic [REC_W-1:0]  mem_q [DEPTH];
   logic [REC_W-1:0]  mem_d [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     count_q, count_d;
   logic [CNT_W-1:0]  dcnt_q, dcnt_d;
   logic              push, pop;

   // First match wins: RI18 opcodes overlap the RI16/RI10 nibble classes.
   always_comb begin
      dec_fmt = FMT_RR;
      dec_rt  = '0;
      dec_ra  = '0;
      dec_rb  = '0;
      dec_rc  = '0;
      dec_en  = 3'b000;
      dec_imm = '0;
      if (instruction[31:28] inside {4'h8, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF}) begin
         dec_fmt = FMT_RRR;
         dec_rt  = REG_AW'(instruction[27:21]);
         dec_rb  = REG_AW'(instruction[20:14]);
         dec_ra  = REG_AW'(instruction[13:7]);
         dec_rc  = REG_AW'(instruction[6:0]);
         dec_en  = 3'b111;
      end else if (instruction[31:25] inside {7'h21, 7'h08, 7'h09}) begin
         dec_fmt = FMT_RI18;
         dec_rt  = REG_AW'(instruction[6:0]);
         dec_imm = {14'b0, instruction[24:7]};
      end else if (instruction[31:28] inside {4'h2, 4'h4}) begin
         dec_fmt = FMT_RI16;
         dec_rt  = REG_AW'(instruction[6:0]);
         dec_imm = {{16{instruction[22]}}, instruction[22:7]};
      end else if (instruction[31:28] inside {4'h0, 4'h1, 4'h3, 4'h5, 4'h7}) begin
         dec_fmt = FMT_RI10;
         dec_rt  = REG_AW'(instruction[6:0]);
         dec_ra  = REG_AW'(instruction[13:7]);
         dec_en  = 3'b100;
         dec_imm = {{22{instruction[23]}}, instruction[23:14]};
      end else begin
         dec_fmt = FMT_RR;
         dec_rt  = REG_AW'(instruction[6:0]);
         dec_ra  = REG_AW'(instruction[13:7]);
         dec_rb  = REG_AW'(instruction[20:14]);
         dec_en  = 3'b110;
      end
   end

   assign dec_rec = {dec_fmt, instruction[31:21], dec_rt, dec_ra, dec_rb, dec_rc,
                     dec_en, dec_imm, pc_plus8_in};

   // in_ready depends only on registered occupancy, never on out_ready.
   assign in_ready  = (count_q < CW'(DEPTH));
   assign out_valid = (count_q != '0);
   assign push      = in_valid & in_ready & ~flush;
   assign pop       = out_valid & out_ready & ~flush;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      dcnt_d   = dcnt_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) begin
            mem_d[wr_ptr_q] = dec_rec;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
      if (push && (dcnt_q != '1)) begin
         dcnt_d = dcnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         dcnt_q   <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         dcnt_q   <= dcnt_d;
      end
   end

   assign {fmt, opcode, rt, ra, rb, rc, ra_en, rb_en, rc_en, imm, pc_plus8_out} = mem_q[rd_ptr_q];
   assign decoded_count = dcnt_q;

endmodule

// File: tb/tb_spu_decode_stage.sv
// Directed bench for spu_decode_stage: format decode, backpressure, streaming,
// flush and mid-stream reset, checked against hand-computed values.
module tb_spu_decode_stage;

   logic        clk = 1'b0;
   logic        reset, flush, in_valid, out_ready;
   logic        in_ready, out_valid;
   logic [31:0] instruction;
   logic [31:0] pc_plus8_in, pc_plus8_out;
   logic [2:0]  fmt;
   logic [10:0] opcode;
   logic [6:0]  rt, ra, rb, rc;
   logic        ra_en, rb_en, rc_en;
   logic [31:0] imm;
   logic [31:0] decoded_count;

   int checks   = 0;
   int failures = 0;

   spu_decode_stage #(.DEPTH(2), .PC_W(32), .REG_AW(7), .CNT_W(32)) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .instruction(instruction), .pc_plus8_in(pc_plus8_in),
      .out_valid(out_valid), .out_ready(out_ready),
      .fmt(fmt), .opcode(opcode), .rt(rt), .ra(ra), .rb(rb), .rc(rc),
      .ra_en(ra_en), .rb_en(rb_en), .rc_en(rc_en), .imm(imm),
      .pc_plus8_out(pc_plus8_out), .decoded_count(decoded_count)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // RI18 instruction whose immediate and rt both equal i (i < 128).
   function automatic logic [31:0] mk(input int i);
      return 32'h4200_0000 | (32'(i) << 7) | (32'(i) & 32'h7F);
   endfunction

   task automatic send(input logic [31:0] ins, input logic [31:0] pc);
      instruction = ins;
      pc_plus8_in = pc;
      in_valid    = 1'b1;
      tick();
      in_valid    = 1'b0;
   endtask

   task automatic pop_one();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   initial begin
      reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      instruction = '0; pc_plus8_in = '0;
      tick();
      tick();
      reset = 1'b0;

      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_fmt", fmt, 0);
      chk("rst_rt", rt, 0);
      chk("rst_imm", imm, 0);
      chk("rst_pc", pc_plus8_out, 0);
      chk("rst_count", decoded_count, 0);

      send(32'hC0A0C101, 32'h108);
      chk("rrr_valid", out_valid, 1);
      chk("rrr_fmt", fmt, 1);
      chk("rrr_regs", {rt, rb, ra, rc}, {7'd5, 7'd3, 7'd2, 7'd1});
      chk("rrr_en", {ra_en, rb_en, rc_en}, 3'b111);
      chk("rrr_imm", imm, 0);
      chk("rrr_pc", pc_plus8_out, 32'h108);
      chk("rrr_opcode", opcode, 11'h605);
      pop_one();
      chk("rrr_drained", out_valid, 0);

      send(32'h1CFFC209, 32'h110);
      chk("ri10_fmt", fmt, 2);
      chk("ri10_rt_ra", {rt, ra}, {7'd9, 7'd4});
      chk("ri10_en", {ra_en, rb_en, rc_en}, 3'b100);
      chk("ri10_imm", imm, 32'hFFFFFFFF);
      pop_one();

      send(32'h40C00003, 32'h118);
      chk("ri16_fmt", fmt, 3);
      chk("ri16_rt", rt, 3);
      chk("ri16_en", {ra_en, rb_en, rc_en}, 3'b000);
      chk("ri16_imm", imm, 32'hFFFF8000);
      pop_one();

      send(32'h43FFFF87, 32'h120);
      chk("ri18_fmt", fmt, 4);
      chk("ri18_rt", rt, 7);
      chk("ri18_imm", imm, 32'h0003FFFF);
      pop_one();

      send(32'h600CD111, 32'h128);
      chk("rr_fmt", fmt, 0);
      chk("rr_regs", {rt, ra, rb, rc}, {7'h11, 7'h22, 7'h33, 7'h00});
      chk("rr_en", {ra_en, rb_en, rc_en}, 3'b110);
      chk("rr_imm", imm, 0);
      chk("rr_opcode", opcode, 11'h300);
      pop_one();
      chk("count_after_formats", decoded_count, 5);

      // Backpressure: three back-to-back pushes into a depth-2 FIFO.
      in_valid = 1'b1;
      instruction = mk(1); pc_plus8_in = 32'h201;
      tick();
      chk("bp_ready_after1", in_ready, 1);
      instruction = mk(2); pc_plus8_in = 32'h202;
      tick();
      chk("bp_full_ready", in_ready, 0);
      instruction = mk(3); pc_plus8_in = 32'h203;
      tick();
      chk("bp_held_ready", in_ready, 0);
      chk("bp_head_A", imm, 1);
      chk("bp_count_held", decoded_count, 7);
      out_ready = 1'b1;
      tick();
      chk("bp_ready_after_pop", in_ready, 1);
      chk("bp_head_B", imm, 2);
      tick();
      in_valid = 1'b0;
      chk("bp_head_C", imm, 3);
      chk("bp_pc_C", pc_plus8_out, 32'h203);
      tick();
      chk("bp_drained", out_valid, 0);
      chk("bp_count", decoded_count, 8);

      // Streaming with out_ready held high.
      in_valid = 1'b1;
      for (int i = 0; i < 16; i++) begin
         instruction = mk(16 + i);
         pc_plus8_in = 32'h1000 + 32'(4 * i);
         tick();
         chk("stream_valid", out_valid, 1);
         chk("stream_imm", imm, 64'(16 + i));
         chk("stream_pc", pc_plus8_out, 64'(32'h1000 + 32'(4 * i)));
      end
      in_valid = 1'b0;
      tick();
      chk("stream_drained", out_valid, 0);
      chk("stream_count", decoded_count, 24);
      out_ready = 1'b0;

      // Flush with two entries buffered and an input presented.
      send(mk(40), 32'h300);
      send(mk(41), 32'h304);
      chk("fl_full", in_ready, 0);
      in_valid = 1'b1; instruction = mk(42); flush = 1'b1;
      tick();
      flush = 1'b0; in_valid = 1'b0;
      chk("fl_out_valid", out_valid, 0);
      chk("fl_in_ready", in_ready, 1);
      chk("fl_count", decoded_count, 26);
      send(mk(43), 32'h30C);
      chk("fl_next_valid", out_valid, 1);
      chk("fl_next_imm", imm, 43);
      chk("fl_next_count", decoded_count, 27);
      pop_one();
      chk("fl_drained", out_valid, 0);

      // Reset while full with out_ready high.
      send(mk(50), 32'h400);
      send(mk(51), 32'h404);
      out_ready = 1'b1; reset = 1'b1;
      tick();
      reset = 1'b0; out_ready = 1'b0;
      chk("mr_out_valid", out_valid, 0);
      chk("mr_in_ready", in_ready, 1);
      chk("mr_fields", {fmt, rt, imm}, 0);
      chk("mr_pc", pc_plus8_out, 0);
      chk("mr_count", decoded_count, 0);
      send(32'h1CFFC209, 32'h500);
      chk("mr_push_fmt", fmt, 2);
      chk("mr_push_imm", imm, 32'hFFFFFFFF);
      chk("mr_push_pc", pc_plus8_out, 32'h500);
      chk("mr_push_count", decoded_count, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
